rr_stream_merge: RTL and testbench

//  Round-robin merger sharing one downstream req/ack port among NUM_SRC upstream req/ack sources (async_operator

---
 rtl/rr_stream_merge.sv | 136 +++++++++++++
 tb/tb_rr_stream_merge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_merge.sv
// Round-robin merge of NUM_SRC req/ack sources onto one downstream req/ack port.
// A source that has not acked within TIMEOUT cycles is skipped; one DRAIN cycle catches a late ack.
module rr_stream_merge #(
  parameter int data_width = 32,
  parameter int NUM_SRC    = 4,
  parameter int TIMEOUT    = 16,
  localparam int SEL_W     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_en,
  output logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC-1:0]            src_ack,
  input  logic [data_width*NUM_SRC-1:0] src_din,
  input  logic                          dout_req,
  output logic                          dout_ack,
  output logic [data_width-1:0]         dout,
  output logic [SEL_W-1:0]              grant,
  output logic [31:0]                   timeout_cnt
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_e;

  state_e                               state_q, state_d;
  logic [SEL_W-1:0]                     ptr_q, ptr_d;
  logic [SEL_W-1:0]                     grant_q, grant_d;
  logic [NUM_SRC-1:0]                   src_req_q, src_req_d;
  logic [data_width-1:0]                dout_q, dout_d;
  logic                                 dout_ack_q, dout_ack_d;
  logic [WC_W-1:0]                      wcnt_q, wcnt_d;
  logic [31:0]                          tcnt_q, tcnt_d;

  logic [NUM_SRC-1:0][data_width-1:0]   din_a;
  logic                                 found;
  logic [SEL_W-1:0]                     pick;
  logic [SEL_W-1:0]                     nxt_g;

  assign din_a = src_din;

  // First enabled source at or after the rotating pointer.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr_q) + k) % NUM_SRC;
      if (!found && src_en[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  assign nxt_g = (grant_q == SEL_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    src_req_d  = src_req_q;
    dout_d     = dout_q;
    dout_ack_d = 1'b0;
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      S_IDLE: begin
        // Holding off while dout_ack is high keeps the ack a single-cycle pulse.
        if (dout_req && !dout_ack_q && found) begin
          grant_d   = pick;
          src_req_d = NUM_SRC'(1) << pick;
          wcnt_d    = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (src_ack[grant_q]) begin
          dout_d     = din_a[grant_q];
          dout_ack_d = 1'b1;
          src_req_d  = '0;
          ptr_d      = nxt_g;
          state_d    = S_IDLE;
        end else if (TIMEOUT != 0 && wcnt_q == WC_W'(TIMEOUT - 1)) begin
          src_req_d = '0;
          state_d   = S_DRAIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (src_ack[grant_q]) begin
          dout_d     = din_a[grant_q];
          dout_ack_d = 1'b1;
          ptr_d      = nxt_g;
          state_d    = S_IDLE;
        end else begin
          tcnt_d  = tcnt_q + 32'd1;
          ptr_d   = nxt_g;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      src_req_q  <= '0;
      dout_q     <= '0;
      dout_ack_q <= 1'b0;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      src_req_q  <= src_req_d;
      dout_q     <= dout_d;
      dout_ack_q <= dout_ack_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign src_req     = src_req_q;
  assign dout_ack    = dout_ack_q;
  assign dout        = dout_q;
  assign grant       = grant_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_rr_stream_merge.sv
// Randomized bench for rr_stream_merge: behavioural sources, queue-based rotation model, scoreboard monitor.
module tb_rr_stream_merge;
  localparam int NS = 4, DW = 32, TO = 16;

  logic            clk = 1'b0, rst = 1'b1;
  logic [NS-1:0]   src_en = '0;
  logic [NS-1:0]   src_req;
  logic [NS-1:0]   src_ack = '0;
  logic [NS*DW-1:0] src_din = '0;
  logic            dout_req = 1'b0;
  logic            dout_ack;
  logic [DW-1:0]   dout;
  logic [1:0]      grant;
  logic [31:0]     timeout_cnt;

  always #5 clk = ~clk;

  rr_stream_merge #(.data_width(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .src_req(src_req), .src_ack(src_ack),
    .src_din(src_din), .dout_req(dout_req), .dout_ack(dout_ack), .dout(dout),
    .grant(grant), .timeout_cnt(timeout_cnt)
  );

  typedef struct packed { logic [1:0] src; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   tests = 0, fails = 0;

  // Source behaviour: 0 = acks after random delay, 1 = never acks, 2 = acks only in the cycle after req drops.
  int   mode[NS] = '{default: 0};
  int   sn[NS]   = '{default: 0};
  int   dly[NS]  = '{default: 0};
  logic [NS-1:0] prev_req = '0;
  bit   stray_en = 1'b0;

  // Reference model state: rotation pointer, per-source word index, expected skip count.
  int   mptr = 0, mto = 0;
  int   mn[NS] = '{default: 0};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst || src_ack[i]) src_ack[i] = 1'b0;
      else if (mode[i] == 0 && src_req[i]) begin
        if (dly[i] == 0) begin
          src_ack[i] = 1'b1;
          src_din[i*DW +: DW] = DW'(i * 1000 + sn[i]);
          sn[i]++;
          dly[i] = $urandom_range(3);
        end else dly[i]--;
      end else if (mode[i] == 2 && prev_req[i] && !src_req[i]) begin
        src_ack[i] = 1'b1;
        src_din[i*DW +: DW] = DW'(i * 1000 + sn[i]);
        sn[i]++;
      end else if (stray_en && src_req != '0 && !src_req[i] && $urandom_range(3) == 0) begin
        src_ack[i] = 1'b1;
        src_din[i*DW +: DW] = 32'hDEAD_0000 | DW'(i);
      end
      prev_req[i] = rst ? 1'b0 : src_req[i];
    end
  end

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_ack = 1'b0;
    else begin
      if (dout_ack) begin
        if (prev_ack) chk("ack_gap", prev_ack, 0);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: dout=%0h grant=%0d with nothing expected", dout, grant);
        end else begin
          e = sb.pop_front();
          chk("dout", dout, e.data);
          chk("grant", grant, e.src);
        end
      end
      prev_ack = dout_ack;
    end
  end

  // A source that never acks in time must see its request held for exactly TIMEOUT cycles.
  int rlen[NS] = '{default: 0};
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) rlen[i] = 0;
      else if (src_req[i]) rlen[i]++;
      else begin
        if (rlen[i] != 0 && mode[i] != 0) chk("req_width", rlen[i], TO);
        rlen[i] = 0;
      end
    end
  end

  task automatic issue_one();
    int n;
    logic [31:0] t0;
    repeat ($urandom_range(2)) @(negedge clk);
    dout_req = 1'b1;
    n = 0;
    while (src_req == '0 && n < 100) begin @(negedge clk); n++; end
    dout_req = 1'b0;
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL grant_wait: src_req=%0h after 100 cycles, required nonzero", src_req);
      return;
    end
    t0 = timeout_cnt;
    n = 0;
    while (!dout_ack && timeout_cnt == t0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL done_wait: no dout_ack or skip within 100 cycles");
    end
  endtask

  task automatic run_phase(string tag, logic [NS-1:0] en, int nwords);
    int g, grants, got;
    src_en = en;
    grants = 0;
    got = 0;
    while (got < nwords) begin
      g = -1;
      for (int k = 0; k < NS; k++) begin
        int idx = (mptr + k) % NS;
        if (g < 0 && en[idx]) g = idx;
      end
      mptr = (g + 1) % NS;
      grants++;
      if (mode[g] == 1) mto++;
      else begin
        sb.push_back('{src: 2'(g), data: DW'(g * 1000 + mn[g])});
        mn[g]++;
        got++;
      end
    end
    for (int k = 0; k < grants; k++) issue_one();
    repeat (3) @(negedge clk);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_timeouts"}, timeout_cnt, mto);
  endtask

  initial begin
    int bad, n;
    logic [NS-1:0] en;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_src_req", src_req, 0);
    chk("rst_dout_ack", dout_ack, 0);
    chk("rst_dout", dout, 0);
    chk("rst_grant", grant, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);

    run_phase("fair", 4'b1111, 100);
    run_phase("mask", 4'b1010, 20);

    src_en = '0;
    dout_req = 1'b1;
    bad = 0;
    repeat (30) begin @(negedge clk); if (src_req != '0) bad++; end
    dout_req = 1'b0;
    chk("disabled_no_req", bad, 0);

    mode[2] = 1;
    run_phase("timeout", 4'b1111, 12);
    mode[2] = 2;
    run_phase("drain", 4'b0100, 3);
    mode[2] = 0;

    stray_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      en = NS'($urandom_range(15, 1));
      run_phase("rand", en, 30);
    end
    stray_en = 1'b0;

    // Reset in the middle of a request; the rotation must restart at source 0.
    for (int i = 0; i < NS; i++) mode[i] = 1;
    src_en = 4'b1111;
    dout_req = 1'b1;
    n = 0;
    while (src_req == '0 && n < 100) begin @(negedge clk); n++; end
    dout_req = 1'b0;
    chk("pre_reset_req_seen", src_req != '0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2_src_req", src_req, 0);
    chk("rst2_dout_ack", dout_ack, 0);
    chk("rst2_grant", grant, 0);
    chk("rst2_timeout_cnt", timeout_cnt, 0);
    mptr = 0;
    mto = 0;
    for (int i = 0; i < NS; i++) mode[i] = 0;
    run_phase("post_reset", 4'b1111, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
